mvm_packet_tx: RTL
==================

# mvm_packet_tx

Host-side AXI-Stream packet transmitter for the MVM mesh ingress port. It takes a packet command (destination, user field, beat count) and a raw word stream, and emits framed AXI-Stream packets with TDEST, TUSER, TID and TLAST. It optionally byte-reverses each word so host-order data matches the lane order the MVMs emit onto the NoC. It sits between the host/DMA logic and the mesh top-level slave stream port.

## Interface
- DATAW, 512, data word width; multiple of 8
- IDW, 32, TID width; carries the packet sequence number
- USERW, 32, TUSER width
- DESTW, 4, TDEST width
- LENW, 8, packet length field width
- BYTE_SWAP, 1, 1 = reverse byte order of every data word; 0 = pass through unchanged

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  packet command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_dest  in  DESTW  destination tile
- cmd_user  in  USERW  user/opcode field for the whole packet
- cmd_len  in  LENW  beats minus one (0 = 1 beat, 255 = 256 beats)
- data_valid  in  1  payload word valid
- data_ready  out  1  payload word accepted
- data  in  DATAW  payload word
- axis_tx_tvalid  out  1  AXIS master valid
- axis_tx_tready  in  1  AXIS master ready
- axis_tx_tdata  out  DATAW  payload; byte-reversed when BYTE_SWAP=1
- axis_tx_tlast  out  1  last beat of packet
- axis_tx_tuser  out  USERW  cmd_user, constant for the packet
- axis_tx_tdest  out  DESTW  cmd_dest, constant for the packet
- axis_tx_tid  out  IDW  packet sequence number
- busy  out  1  packet in progress, or output register holds a beat
- pkt_count  out  IDW  packets fully sent (TLAST handshakes)

## Operation
- FSM states are IDLE and SEND.
- **IDLE**
  - cmd_ready=1 and data_ready=0.
  - On cmd_valid, latch dest, user and len, clear beat_cnt, and go to SEND.
- **SEND**
  - cmd_ready=0.
  - data_ready = !axis_tx_tvalid || axis_tx_tready, so there is one output register stage.
  - On each data handshake: load the output register, set tlast = (beat_cnt == len), and increment beat_cnt.
  - On the handshake of the last beat: return to IDLE.
- **Sequence number**
  - axis_tx_tid takes the sequence counter value latched at command accept.
  - The counter increments on every command accept and wraps modulo 2^IDW.
- **pkt_count** increments on every axis_tx_tvalid && axis_tx_tready && axis_tx_tlast. It wraps modulo 2^IDW.
- **Byte reversal:** output byte k is input byte (DATAW/8-1-k). The order is identical for every beat.
- **AXIS rules**
  - Once tvalid rises, tvalid and all payload fields stay stable until tready.
  - tvalid never depends combinationally on tready.

## Timing
- **Reset values:** state=IDLE, cmd_ready=1 (it reflects the state), data_ready=0. All axis_tx_* outputs are 0, busy=0, pkt_count=0, and the sequence counter is 0.
- **Command to first data_ready:** 1 cycle. A command accepted at cycle t gives data_ready possible at t+1.
- **Data to output:** 1 cycle. A word accepted at cycle t appears on axis_tx_* at t+1.
- **Throughput:** 1 beat/cycle within a packet while tready stays high.
- **Bubble between packets:** 1 cycle, the IDLE command-accept cycle.
  - The last beat may still be held in the output register while the next command is accepted.
  - Its tlast, tuser, tdest and tid are unaffected by the new command.
- **Backpressure:** when tready=0 with tvalid=1, data_ready=0 and beat_cnt holds.
- **Simultaneous events:** a same-cycle output handshake and input load replaces the register with no gap.
- **Reset mid-packet:** the partial packet is discarded, tvalid drops asynchronously, and no tlast is emitted. The next packet starts with tid=0.
- **Maximum length:** cmd_len=2^LENW-1 gives 2^LENW beats. beat_cnt is LENW bits wide and does not overflow before TLAST.

## Structure
- Package mvm_tx_pkg holds:
  - the state enum typedef (IDLE, SEND);
  - a parameterised byte_reverse function;
  - the default width localparams matching the shared mesh parameters.
- One sub-module, axis_out_reg, is the single-entry AXIS output register with the ready-propagation rule above. The top contains the FSM, counters and field latches.

## Test plan
- **Single beat, no backpressure:** cmd_len=0, dest=3, user=0xA5, tready=1, data=0x00..3F (byte k = k) -> one beat.
  - tlast=1, tdest=3, tuser=0xA5, tid=0.
  - tdata byte k = 63-k.
  - pkt_count=1.
- **Four-beat packet with BYTE_SWAP=0:** tready toggled 1,0,0,1,… -> 4 beats, each matching its input exactly.
  - tlast only on beat 4.
  - No beat dropped or duplicated.
  - Payload stable while tready=0.
- **Back-to-back commands:** two commands, len=1 and len=2 -> 5 beats total, tid 0,0,1,1,1.
  - Exactly one idle cycle between the packets.
  - tdest/tuser switch only on the first beat of packet 2.
- **Maximum length:** cmd_len=255 -> 256 beats, tlast on beat 256 only, pkt_count=1.
- **Reset mid-packet:** rst asserted after beat 2 of a len=7 packet.
  - tvalid=0 immediately; all outputs return to reset values.
  - A following len=0 packet sends with tid=0 and pkt_count=1.
- **Sequence wrap:** IDW=2, five packets -> tid 0,1,2,3,0 and pkt_count wraps to 1.

Source files
------------

// File: rtl/mvm_tx_pkg.sv
// Shared types, default widths and the byte-reversal helper for the MVM packet transmitter.
package mvm_tx_pkg;

    localparam int unsigned DATAW_DEF = 512;
    localparam int unsigned IDW_DEF   = 32;
    localparam int unsigned USERW_DEF = 32;
    localparam int unsigned DESTW_DEF = 4;
    localparam int unsigned LENW_DEF  = 8;

    // Widest word byte_reverse handles; narrower words are zero-extended into it.
    localparam int unsigned MAX_DATAW = DATAW_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Output byte k takes input byte (nbytes-1-k); bytes at or above nbytes are zero.
    function automatic logic [MAX_DATAW-1:0] byte_reverse(input logic [MAX_DATAW-1:0] d,
                                                          input int unsigned nbytes);
        logic [MAX_DATAW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < MAX_DATAW / 8; k++) begin
            if (k < nbytes) begin
                r[8*k +: 8] = d[8*(nbytes-1-k) +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register; accepts a new beat whenever it is empty or draining.
module axis_out_reg #(
    parameter int unsigned DATAW = 512,
    parameter int unsigned USERW = 32,
    parameter int unsigned DESTW = 4,
    parameter int unsigned IDW   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_last,
    input  logic [USERW-1:0] in_user,
    input  logic [DESTW-1:0] in_dest,
    input  logic [IDW-1:0]   in_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_last,
    output logic [USERW-1:0] out_user,
    output logic [DESTW-1:0] out_dest,
    output logic [IDW-1:0]   out_id
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
            out_dest  <= '0;
            out_id    <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
            out_user  <= in_user;
            out_dest  <= in_dest;
            out_id    <= in_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mvm_packet_tx.sv
// Host-side packet framer: turns a command plus raw words into AXI-Stream packets for the mesh.
module mvm_packet_tx
    import mvm_tx_pkg::*;
#(
    parameter int unsigned DATAW     = DATAW_DEF,
    parameter int unsigned IDW       = IDW_DEF,
    parameter int unsigned USERW     = USERW_DEF,
    parameter int unsigned DESTW     = DESTW_DEF,
    parameter int unsigned LENW      = LENW_DEF,
    parameter bit          BYTE_SWAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DESTW-1:0] cmd_dest,
    input  logic [USERW-1:0] cmd_user,
    input  logic [LENW-1:0]  cmd_len,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic [DATAW-1:0] data,
    output logic             axis_tx_tvalid,
    input  logic             axis_tx_tready,
    output logic [DATAW-1:0] axis_tx_tdata,
    output logic             axis_tx_tlast,
    output logic [USERW-1:0] axis_tx_tuser,
    output logic [DESTW-1:0] axis_tx_tdest,
    output logic [IDW-1:0]   axis_tx_tid,
    output logic             busy,
    output logic [IDW-1:0]   pkt_count
);

    tx_state_t          state;
    logic [DESTW-1:0]   dest_q;
    logic [USERW-1:0]   user_q;
    logic [LENW-1:0]    len_q;
    logic [LENW-1:0]    beat_cnt;
    logic [IDW-1:0]     seq_cnt;
    logic [IDW-1:0]     tid_q;
    logic               reg_ready;
    logic               cmd_hs;
    logic               data_hs;
    logic               last_beat;
    logic [MAX_DATAW-1:0] data_ext;
    logic [MAX_DATAW-1:0] data_rev;
    logic [DATAW-1:0]   word;

    assign cmd_ready  = (state == IDLE);
    assign data_ready = (state == SEND) && reg_ready;
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign data_hs    = data_valid && data_ready;
    assign last_beat  = (beat_cnt == len_q);
    assign busy       = (state == SEND) || axis_tx_tvalid;

    always_comb begin
        data_ext              = '0;
        data_ext[DATAW-1:0]   = data;
        data_rev              = byte_reverse(data_ext, DATAW / 8);
        word                  = BYTE_SWAP ? data_rev[DATAW-1:0] : data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dest_q   <= '0;
            user_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            seq_cnt  <= '0;
            tid_q    <= '0;
        end else if (cmd_hs) begin
            dest_q   <= cmd_dest;
            user_q   <= cmd_user;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            tid_q    <= seq_cnt;
            seq_cnt  <= seq_cnt + 1'b1;
            state    <= SEND;
        end else if (data_hs) begin
            // Wraps to zero on the 2^LENW-th beat, which is always the last one.
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (axis_tx_tvalid && axis_tx_tready && axis_tx_tlast) begin
            pkt_count <= pkt_count + 1'b1;
        end
    end

    axis_out_reg #(
        .DATAW (DATAW),
        .USERW (USERW),
        .DESTW (DESTW),
        .IDW   (IDW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (data_valid && (state == SEND)),
        .in_ready  (reg_ready),
        .in_data   (word),
        .in_last   (last_beat),
        .in_user   (user_q),
        .in_dest   (dest_q),
        .in_id     (tid_q),
        .out_valid (axis_tx_tvalid),
        .out_ready (axis_tx_tready),
        .out_data  (axis_tx_tdata),
        .out_last  (axis_tx_tlast),
        .out_user  (axis_tx_tuser),
        .out_dest  (axis_tx_tdest),
        .out_id    (axis_tx_tid)
    );

endmodule
